vblank_write_arbiter: RTL and testbench

- Shares the single write port of the 12-bit RGB frame memory between two requesters: game logic (ch0) and debug/UART loader (ch1).
- Grants writes only during vertical blanking, so the scan-out read path feeding the VGA display driver never sees a write during visible lines.
- Tracks the raster line from the display driver's hsync/vsync.
- Round-robin arbitration; at most one word is transferred per clock.

---
 rtl/vblank_write_arbiter.sv | 136 +++++++++++++
 tb/tb_vblank_write_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vblank_write_arbiter.sv
// Frame-memory write arbiter: round-robin between two writers, granting only during vertical blanking.
// Optional FRAME_CNT_EN adds a 16-bit frame_count output counting locked frames.
module vblank_write_arbiter #(
  parameter int ADDR_W    = 17,
  parameter int VIS_START = 35,
  parameter int VIS_END   = 515,
  parameter int LINES     = 525
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hsync,
  input  logic              vsync,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [11:0]       data0,
  input  logic [11:0]       data1,
  output logic              ack0,
  output logic              ack1,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [11:0]       mem_data,
  output logic              in_blank,
  output logic              frame_start,
`ifdef FRAME_CNT_EN
  output logic [15:0]       frame_count,
`endif
  output logic [9:0]        line
);

  typedef enum logic [1:0] {UNLOCKED, BLANK, ACTIVE} state_t;

  localparam logic [9:0] VIS_START_L = 10'(VIS_START);
  localparam logic [9:0] VIS_END_L   = 10'(VIS_END);
  localparam logic [9:0] LAST_LINE   = 10'(LINES - 1);

  state_t            state_q, state_d;
  logic [9:0]        line_q, line_d;
  logic              hsync_q, vsync_q;
  logic              ptr_q, ptr_d;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [11:0]       mem_data_q;
  logic              frame_start_q;
  logic              hs_fall, vs_fall, sync_lost, grant_en, xfer;

  always_comb begin
    hs_fall   = hsync_q & ~hsync;
    vs_fall   = vsync_q & ~vsync;
    sync_lost = 1'b0;
    line_d    = line_q;
    // vsync and hsync fall together at frame wrap; vsync wins
    if (vs_fall) begin
      line_d = '0;
    end else if (hs_fall) begin
      if (line_q == LAST_LINE) begin
        line_d    = '0;
        sync_lost = 1'b1;
      end else begin
        line_d = line_q + 10'd1;
      end
    end

    state_d = state_q;
    if (vs_fall) begin
      state_d = BLANK;
    end else if (sync_lost) begin
      state_d = UNLOCKED;
    end else begin
      case (state_q)
        BLANK:   if (line_d == VIS_START_L) state_d = ACTIVE;
        ACTIVE:  if (line_d == VIS_END_L)   state_d = BLANK;
        default: state_d = state_q;
      endcase
    end

    // ptr_q == 0 favours ch0 on contention
    grant_en = (state_q == BLANK);
    ack0     = grant_en & req0 & (~req1 | ~ptr_q);
    ack1     = grant_en & req1 & (~req0 |  ptr_q);
    xfer     = ack0 | ack1;
    ptr_d    = ptr_q;
    if (ack0)      ptr_d = 1'b1;
    else if (ack1) ptr_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= UNLOCKED;
      line_q        <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      ptr_q         <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_data_q    <= '0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      line_q        <= line_d;
      hsync_q       <= hsync;
      vsync_q       <= vsync;
      ptr_q         <= ptr_d;
      mem_we_q      <= xfer;
      frame_start_q <= vs_fall;
      if (xfer) begin
        mem_addr_q <= ack1 ? addr1 : addr0;
        mem_data_q <= ack1 ? data1 : data0;
      end
    end
  end

`ifdef FRAME_CNT_EN
  logic [15:0] frame_count_q;

  // The relock edge after sync loss is not counted
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_count_q <= '0;
    end else if (vs_fall && state_q != UNLOCKED) begin
      frame_count_q <= frame_count_q + 16'd1;
    end
  end

  assign frame_count = frame_count_q;
`endif

  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_data    = mem_data_q;
  assign in_blank    = (state_q == BLANK);
  assign frame_start = frame_start_q;
  assign line        = line_q;

endmodule

// File: tb/tb_vblank_write_arbiter.sv
// Randomised and directed bench for vblank_write_arbiter with a line-count/blanking reference model.
module tb_vblank_write_arbiter;
  localparam int AW    = 17;
  localparam int HP    = 8;     // clocks per line (shortened display timing)
  localparam int LINES = 525;

  logic          clk = 1'b0, reset = 1'b0, hsync = 1'b1, vsync = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [11:0]   data0 = '0, data1 = '0;
  logic          ack0, ack1, mem_we, in_blank, frame_start;
  logic [AW-1:0] mem_addr;
  logic [11:0]   mem_data;
  logic [9:0]    line;
`ifdef FRAME_CNT_EN
  logic [15:0]   frame_count;
`endif

  vblank_write_arbiter #(.ADDR_W(AW), .VIS_START(35), .VIS_END(515), .LINES(LINES)) dut (
    .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1), .data0(data0), .data1(data1),
    .ack0(ack0), .ack1(ack1), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .in_blank(in_blank), .frame_start(frame_start),
`ifdef FRAME_CNT_EN
    .frame_count(frame_count),
`endif
    .line(line)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // display driver generator
  int gen_h = 0, gen_line = 200;
  bit gen_vs_en = 1'b1;

  // reference model: line = hsync falls since last vsync fall; blanking by line range while locked
  bit            m_hs_prev = 1, m_vs_prev = 1, m_locked = 0, m_last = 1, m_pend = 0, m_fs = 0;
  int            m_line = 0, m_fc = 0;
  logic [AW-1:0] m_paddr = '0;
  logic [11:0]   m_pdata = '0;
  bit            e_ack0, e_ack1, a_ack0, a_ack1;

  function automatic bit m_en();
    return m_locked && (m_line < 35 || m_line >= 515);
  endfunction

  task automatic model_reset();
    m_hs_prev = 1; m_vs_prev = 1; m_locked = 0; m_last = 1; m_pend = 0; m_fs = 0;
    m_line = 0; m_fc = 0; m_paddr = '0; m_pdata = '0;
  endtask

  // One clock: drive sync, sample acks, advance the model, move to posedge+1
  task automatic tick();
    bit hs_f, vs_f;
    hsync = (gen_h != 0);
    vsync = !(gen_vs_en && gen_line < 2);
    #1;
    a_ack0 = ack0; a_ack1 = ack1;
    e_ack0 = m_en() && req0 && (!req1 || m_last);
    e_ack1 = m_en() && req1 && (!req0 || !m_last);
    if (!reset) begin
      model_reset();
    end else begin
      hs_f = m_hs_prev && !hsync;
      vs_f = m_vs_prev && !vsync;
      m_pend = e_ack0 || e_ack1;
      if (e_ack0) begin m_paddr = addr0; m_pdata = data0; m_last = 0; end
      else if (e_ack1) begin m_paddr = addr1; m_pdata = data1; m_last = 1; end
      m_fs = vs_f;
      if (vs_f) begin
        if (m_locked) m_fc = (m_fc + 1) % 65536;
        m_line = 0; m_locked = 1;
      end else if (hs_f) begin
        if (m_line == LINES - 1) begin m_line = 0; m_locked = 0; end
        else m_line++;
      end
      m_hs_prev = hsync; m_vs_prev = vsync;
    end
    gen_h = (gen_h + 1) % HP;
    if (gen_h == 0) gen_line = (gen_line + 1) % LINES;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    bit seen = 0;
    req0 = 1; addr0 = 17'd3; data0 = 12'h0A0;
    repeat (3) tick();
    checks++; if (line !== 10'd0) begin errors++; $display("FAIL reset_line got=%0d exp=0", line); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", mem_we); end
    checks++; if (mem_addr !== '0 || mem_data !== '0) begin errors++; $display("FAIL reset_addr_data got=%0h/%0h exp=0/0", mem_addr, mem_data); end
    checks++; if (frame_start !== 1'b0 || in_blank !== 1'b0) begin errors++; $display("FAIL reset_flags fs=%b blank=%b exp=0/0", frame_start, in_blank); end
    checks++; if (a_ack0 !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0", a_ack0); end
    reset = 1;
    for (int i = 0; i < 2 * LINES * HP && !seen; i++) begin
      tick();
      checks++; if (a_ack0 !== 1'b0) begin errors++; $display("FAIL prelock_ack cyc=%0d got=%b exp=0", i, a_ack0); end
      if (frame_start === 1'b1) seen = 1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL lock_timeout frame_start got=0 exp=1"); end
    checks++; if (line !== 10'd0 || in_blank !== 1'b1) begin errors++; $display("FAIL lock_state line=%0d blank=%b exp=0/1", line, in_blank); end
    tick();
    checks++; if (a_ack0 !== 1'b1 || frame_start !== 1'b0) begin errors++; $display("FAIL lock_ack ack0=%b fs=%b exp=1/0", a_ack0, frame_start); end
    req0 = 0;
    $display("reset/lock: first grant after vsync edge, line=%0d", line);
  endtask

  task automatic test_single_write();
    req0 = 0; req1 = 0;
    for (int i = 0; i < LINES * HP && !(m_locked && m_line == 10); i++) tick();
    req0 = 1; addr0 = 17'd5; data0 = 12'hF00;
    tick();
    req0 = 0;
    checks++; if (a_ack0 !== 1'b1 || a_ack1 !== 1'b0) begin errors++; $display("FAIL single_ack ack0=%b ack1=%b exp=1/0", a_ack0, a_ack1); end
    checks++; if (mem_we !== 1'b1 || mem_addr !== 17'd5 || mem_data !== 12'hF00) begin errors++; $display("FAIL single_write we=%b addr=%0d data=%h exp=1/5/f00", mem_we, mem_addr, mem_data); end
    tick();
    checks++; if (mem_we !== 1'b0 || mem_addr !== 17'd5 || mem_data !== 12'hF00) begin errors++; $display("FAIL single_hold we=%b addr=%0d data=%h exp=0/5/f00", mem_we, mem_addr, mem_data); end
    $display("single write: addr=%0d data=%h", mem_addr, mem_data);
  endtask

  task automatic test_back_to_back();
    bit first;
    bit exp;
    first = m_last ? 1'b0 : 1'b1;
    req0 = 1; req1 = 1;
    for (int i = 0; i < 8; i++) begin
      exp = first ^ i[0];
      addr0 = AW'(i); addr1 = AW'(100 + i);
      data0 = 12'(i); data1 = 12'(12'h800 + i);
      tick();
      checks++; if (a_ack0 !== !exp || a_ack1 !== exp) begin errors++; $display("FAIL b2b_ack i=%0d ack0=%b ack1=%b exp_ch=%0d", i, a_ack0, a_ack1, exp); end
      checks++; if (mem_we !== 1'b1 || mem_addr !== (exp ? addr1 : addr0)) begin errors++; $display("FAIL b2b_write i=%0d we=%b addr=%0d exp_ch=%0d", i, mem_we, mem_addr, exp); end
      $display("b2b grant %0d -> ch%0d", i, exp);
    end
    req0 = 0; req1 = 0;
  endtask

  task automatic test_active_hold();
    int  pre;
    bit  last_ch = 0, resumed = 0, got = 0;
    req0 = 0; req1 = 0;
    for (int i = 0; i < LINES * HP && !(m_locked && m_line == 33); i++) tick();
    req0 = 1; req1 = 1;
    for (int i = 0; i < 600 * HP && m_line < 516; i++) begin
      pre = m_line;
      tick();
      checks++; if (a_ack0 !== e_ack0 || a_ack1 !== e_ack1) begin errors++; $display("FAIL hold_ack line=%0d got=%b%b exp=%b%b", pre, a_ack0, a_ack1, e_ack0, e_ack1); end
      if (pre >= 35 && pre <= 514) begin
        checks++; if (a_ack0 || a_ack1 || mem_we !== 1'b0) begin errors++; $display("FAIL active_quiet line=%0d ack=%b%b we=%b exp=00/0", pre, a_ack0, a_ack1, mem_we); end
      end
      checks++; if (line !== 10'(m_line) || in_blank !== m_en()) begin errors++; $display("FAIL hold_line line=%0d blank=%b exp=%0d/%b", line, in_blank, m_line, m_en()); end
      if (pre == 515 && !resumed) begin
        resumed = 1;
        checks++; if (a_ack1 !== !last_ch || a_ack0 !== last_ch) begin errors++; $display("FAIL ptr_preserved ack=%b%b exp_ch=%0d", a_ack0, a_ack1, !last_ch); end
      end
      if (pre < 35 && (a_ack0 || a_ack1)) begin last_ch = a_ack1; got = 1; end
    end
    checks++; if (!resumed || !got) begin errors++; $display("FAIL hold_timeout resumed=%b got=%b exp=1/1", resumed, got); end
    req0 = 0; req1 = 0;
    $display("active hold: grants resumed at line 515");
  endtask

  task automatic test_sync_loss();
    bit relocked = 0;
    int fc_before;
    req0 = 1; req1 = 1;
    for (int i = 0; i < LINES * HP && !(m_locked && gen_line == 5); i++) tick();
    gen_vs_en = 0;
    for (int i = 0; i < 2 * LINES * HP && m_locked; i++) begin
      tick();
      checks++; if (a_ack0 !== e_ack0 || a_ack1 !== e_ack1) begin errors++; $display("FAIL loss_ack got=%b%b exp=%b%b", a_ack0, a_ack1, e_ack0, e_ack1); end
    end
    checks++; if (line !== 10'd0 || in_blank !== 1'b0 || m_locked) begin errors++; $display("FAIL loss_state line=%0d blank=%b exp=0/0", line, in_blank); end
    for (int i = 0; i < 3 * HP && gen_line != 2; i++) begin
      tick();
      checks++; if (a_ack0 || a_ack1) begin errors++; $display("FAIL unlocked_ack got=%b%b exp=00", a_ack0, a_ack1); end
    end
    gen_vs_en = 1;
    fc_before = m_fc;
    for (int i = 0; i < LINES * HP + 16 && !relocked; i++) begin
      tick();
      checks++; if (a_ack0 || a_ack1) begin errors++; $display("FAIL unlocked_ack got=%b%b exp=00", a_ack0, a_ack1); end
      if (frame_start === 1'b1) relocked = 1;
    end
    checks++; if (!relocked || line !== 10'd0 || in_blank !== 1'b1) begin errors++; $display("FAIL relock relocked=%b line=%0d blank=%b exp=1/0/1", relocked, line, in_blank); end
`ifdef FRAME_CNT_EN
    checks++; if (frame_count !== 16'(fc_before)) begin errors++; $display("FAIL relock_count got=%0d exp=%0d", frame_count, fc_before); end
`endif
    tick();
    checks++; if (a_ack0 !== e_ack0 || a_ack1 !== e_ack1 || !(a_ack0 || a_ack1)) begin errors++; $display("FAIL relock_ack got=%b%b exp=%b%b", a_ack0, a_ack1, e_ack0, e_ack1); end
    $display("sync loss: relocked, fc_before=%0d", fc_before);
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    req0 = 1; req1 = 1;
    tick(); tick();
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL mid_pre_we got=%b exp=1", mem_we); end
    reset = 0;
    #1;
    checks++; if (mem_we !== 1'b0 || in_blank !== 1'b0 || line !== 10'd0) begin errors++; $display("FAIL mid_async we=%b blank=%b line=%0d exp=0/0/0", mem_we, in_blank, line); end
    tick(); tick();
    reset = 1;
    for (int i = 0; i < 2 * LINES * HP && !seen; i++) begin
      tick();
      checks++; if (a_ack0 || a_ack1) begin errors++; $display("FAIL mid_prelock_ack got=%b%b exp=00", a_ack0, a_ack1); end
      if (frame_start === 1'b1) seen = 1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL mid_lock_timeout frame_start got=0 exp=1"); end
    tick();
    checks++; if (a_ack0 !== 1'b1 || a_ack1 !== 1'b0) begin errors++; $display("FAIL mid_relock_ack got=%b%b exp=10", a_ack0, a_ack1); end
    $display("reset mid-transfer: relocked after vsync");
  endtask

  task automatic test_random();
    for (int i = 0; i < 4600; i++) begin
      req0  = ($urandom_range(0, 3) != 0);
      req1  = ($urandom_range(0, 3) != 0);
      addr0 = AW'($urandom); addr1 = AW'($urandom);
      data0 = 12'($urandom); data1 = 12'($urandom);
      tick();
      checks++; if (a_ack0 !== e_ack0 || a_ack1 !== e_ack1) begin errors++; $display("FAIL rnd_ack i=%0d got=%b%b exp=%b%b", i, a_ack0, a_ack1, e_ack0, e_ack1); end
      checks++; if (mem_we !== m_pend || mem_addr !== m_paddr || mem_data !== m_pdata) begin errors++; $display("FAIL rnd_write i=%0d got=%b/%0h/%h exp=%b/%0h/%h", i, mem_we, mem_addr, mem_data, m_pend, m_paddr, m_pdata); end
      checks++; if (line !== 10'(m_line) || in_blank !== m_en() || frame_start !== m_fs) begin errors++; $display("FAIL rnd_sync i=%0d line=%0d blank=%b fs=%b exp=%0d/%b/%b", i, line, in_blank, frame_start, m_line, m_en(), m_fs); end
`ifdef FRAME_CNT_EN
      checks++; if (frame_count !== 16'(m_fc)) begin errors++; $display("FAIL rnd_fc i=%0d got=%0d exp=%0d", i, frame_count, m_fc); end
`endif
    end
    req0 = 0; req1 = 0;
    $display("random: 4600 cycles compared");
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_active_hold();
    test_sync_loss();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
